spi_master: RTL and testbench

SPI master shift engine that carries out the transfers the CPU issues through MTC0/MFC0 under the 2-bit spi_mode field.
- Latches a transmit word and mode on a start strobe.
- Drives cs_n, sclk and mosi; samples miso.
- Returns the received word with a one-cycle done pulse.
- Sits beside the register file and is driven by the coprocessor-0 datapath.

---
 rtl/spi_master.sv | 164 ++++++++++++++++
 tb/tb_spi_master.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI master shift engine: latches a word and mode on start, runs one
// MSB-first transfer on sclk/mosi/miso under cs_n, returns rx_data with done.
//
// Ports:
//   clk, rst_n        system clock, async active-low reset
//   start             transfer request, honoured only in IDLE
//   spi_mode[1:0]     [1]=CPOL, [0]=CPHA, latched with start
//   tx_data           word to send, latched with start
//   busy              high from the cycle after start through HOLD
//   done              one-cycle completion pulse
//   rx_data           last received word, updated with done
//   sclk, mosi, cs_n  SPI outputs (all registered)
//   miso              SPI data in
module spi_master #(
    parameter int W_DATA  = 32,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        spi_mode,
    input  logic [W_DATA-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [W_DATA-1:0] rx_data,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * W_DATA);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * W_DATA - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_HOLD,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [DIV_W-1:0]    r_div;
    logic [EDGE_W-1:0]   r_edge;
    logic [W_DATA-1:0]   r_tx;
    logic [W_DATA-1:0]   r_rx;
    logic [W_DATA-1:0]   r_rx_data;
    logic                r_cpol;
    logic                r_cpha;
    logic                r_sclk;
    logic                r_mosi;
    logic                r_cs_n;
    logic                r_busy;
    logic                r_done;

    logic                w_tick;
    logic [EDGE_W-1:0]   w_k;
    logic                w_lead;
    logic                w_shift;
    logic                w_sample;

    // w_k is the index of the sclk edge issued on this tick: the tick that
    // ends SETUP issues edge 0, each XFER tick issues the one after r_edge.
    assign w_tick   = (r_div == DIV_LAST);
    assign w_k      = (r_state == S_SETUP) ? '0 : r_edge + 1'b1;
    assign w_lead   = ~w_k[0];
    assign w_shift  = r_cpha ? (w_lead && (w_k != '0))
                             : (!w_lead && (w_k != EDGE_LAST));
    assign w_sample = r_cpha ? !w_lead : w_lead;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_div     <= '0;
            r_edge    <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rx_data <= '0;
            r_cpol    <= 1'b0;
            r_cpha    <= 1'b0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_cs_n    <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_sclk <= spi_mode[1];
                    r_div  <= '0;
                    if (start) begin
                        r_tx    <= tx_data;
                        r_rx    <= '0;
                        r_cpol  <= spi_mode[1];
                        r_cpha  <= spi_mode[0];
                        r_mosi  <= tx_data[W_DATA-1];
                        r_cs_n  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP, S_XFER: begin
                    if (!w_tick) begin
                        r_div <= r_div + 1'b1;
                    end else begin
                        r_div <= '0;
                        // The tick after the last edge only closes the
                        // final half-period; sclk is already back at CPOL.
                        if (r_state == S_XFER && r_edge == EDGE_LAST) begin
                            r_state <= S_HOLD;
                        end else begin
                            r_state <= S_XFER;
                            r_edge  <= w_k;
                            r_sclk  <= ~r_sclk;
                            if (r_cpha && w_k == '0) begin
                                r_mosi <= r_tx[W_DATA-1];
                            end
                            if (w_shift) begin
                                r_mosi <= r_tx[W_DATA-2];
                                r_tx   <= r_tx << 1;
                            end
                            if (w_sample) begin
                                r_rx <= {r_rx[W_DATA-2:0], miso};
                            end
                        end
                    end
                end
                S_HOLD: begin
                    r_sclk <= r_cpol;
                    if (!w_tick) begin
                        r_div <= r_div + 1'b1;
                    end else begin
                        r_div     <= '0;
                        r_cs_n    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_rx_data <= r_rx;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_edge  <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign rx_data = r_rx_data;
    assign sclk    = r_sclk;
    assign mosi    = r_mosi;
    assign cs_n    = r_cs_n;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: 8-bit/div-2 instance across all modes,
// plus a 32-bit/div-1 loopback instance.
module tb_spi_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start0 = 1'b0;
    logic [1:0]  spi_mode0 = 2'd0;
    logic [7:0]  tx0 = 8'h00;
    logic        busy0, done0, sclk0, mosi0, miso0, cs0_n;
    logic [7:0]  rx0;

    logic        start1 = 1'b0;
    logic [1:0]  spi_mode1 = 2'd0;
    logic [31:0] tx1 = 32'h0;
    logic        busy1, done1, sclk1, mosi1, miso1, cs1_n;
    logic [31:0] rx1;

    logic        loopback = 1'b1;
    logic        s_cpha = 1'b0;
    logic [7:0]  s_word = 8'h00;
    logic [7:0]  s_sh = 8'h00;
    logic [7:0]  s_rx = 8'h00;
    logic        s_miso = 1'b0;
    int          s_k = 0;

    int n_vec = 0;
    int n_mis = 0;

    int done_cyc, done_cnt, busy_bad, n_rise, chg_on, chg_off, cs_after;
    logic cs_at1;

    always #5 clk = ~clk;

    assign miso0 = loopback ? mosi0 : s_miso;
    assign miso1 = mosi1;

    spi_master #(.W_DATA(8), .CLK_DIV(2)) u_dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start0),
        .spi_mode (spi_mode0),
        .tx_data  (tx0),
        .busy     (busy0),
        .done     (done0),
        .rx_data  (rx0),
        .sclk     (sclk0),
        .mosi     (mosi0),
        .miso     (miso0),
        .cs_n     (cs0_n)
    );

    spi_master #(.W_DATA(32), .CLK_DIV(1)) u_dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start1),
        .spi_mode (spi_mode1),
        .tx_data  (tx1),
        .busy     (busy1),
        .done     (done1),
        .rx_data  (rx1),
        .sclk     (sclk1),
        .mosi     (mosi1),
        .miso     (miso1),
        .cs_n     (cs1_n)
    );

    // Independent SPI slave: edge parity since cs_n fell picks leading
    // versus trailing, so it works for either clock polarity.
    always @(negedge cs0_n) begin
        s_k    = 0;
        s_sh   = s_word;
        s_rx   = 8'h00;
        s_miso = s_cpha ? 1'b0 : s_word[7];
    end

    always @(sclk0) begin
        if (!cs0_n) begin
            if (s_k % 2 == 0) begin
                if (!s_cpha) begin
                    s_rx = {s_rx[6:0], mosi0};
                end else begin
                    s_miso = s_sh[7];
                    s_sh   = s_sh << 1;
                end
            end else begin
                if (!s_cpha) begin
                    s_sh   = s_sh << 1;
                    s_miso = s_sh[7];
                end else begin
                    s_rx = {s_rx[6:0], mosi0};
                end
            end
            s_k++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One transfer on the 8-bit instance, observed for 45 cycles.
    // Cycle j is sampled on the falling edge after the j-th rising edge
    // counting the accept edge as the first.
    task automatic xfer(input logic [1:0] mode, input logic [7:0] tx,
                        input int inj, input int rst_at);
        logic prev_sclk;
        logic prev_mosi;
        @(negedge clk);
        spi_mode0 = mode;
        start0    = 1'b0;
        @(negedge clk);
        check("idle_sclk", {31'd0, sclk0}, {31'd0, mode[1]});
        tx0       = tx;
        start0    = 1'b1;
        done_cyc  = 0;
        done_cnt  = 0;
        busy_bad  = 0;
        n_rise    = 0;
        chg_on    = 0;
        chg_off   = 0;
        cs_after  = 0;
        cs_at1    = 1'b1;
        prev_sclk = sclk0;
        prev_mosi = mosi0;
        for (int j = 1; j <= 45; j++) begin
            @(negedge clk);
            if (j == 1) begin
                start0 = 1'b0;
                cs_at1 = cs0_n;
            end
            if (inj > 0 && j == inj + 1) begin
                start0    = 1'b0;
                spi_mode0 = mode;
            end
            if (inj > 0 && j == inj) begin
                start0 = 1'b1;
                tx0    = 8'h00;
                if (inj < 30) spi_mode0 = ~mode;
            end
            if (rst_at > 0 && j == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_cs_n", {31'd0, cs0_n}, 32'd1);
                check("rst_sclk", {31'd0, sclk0}, 32'd0);
                check("rst_busy", {31'd0, busy0}, 32'd0);
                check("rst_rx", {24'd0, rx0}, 32'd0);
            end
            if (rst_at > 0 && j == rst_at + 3) rst_n = 1'b1;
            if (done0) begin
                if (done_cnt == 0) done_cyc = j;
                done_cnt++;
            end
            if (rst_at == 0 && busy0 != (j < 37)) busy_bad++;
            if (done_cnt > 0 && !done0 && !cs0_n) cs_after++;
            if (!cs0_n && j > 1 && mosi0 != prev_mosi) begin
                if (!prev_sclk && sclk0) chg_on++;
                else chg_off++;
            end
            if (!cs0_n && !prev_sclk && sclk0) n_rise++;
            prev_sclk = sclk0;
            prev_mosi = mosi0;
        end
    endtask

    initial begin
        int d1;
        #23;
        check("rst0_cs_n", {31'd0, cs0_n}, 32'd1);
        check("rst0_sclk", {31'd0, sclk0}, 32'd0);
        check("rst0_mosi", {31'd0, mosi0}, 32'd0);
        check("rst0_busy", {31'd0, busy0}, 32'd0);
        check("rst0_done", {31'd0, done0}, 32'd0);
        check("rst0_rx", {24'd0, rx0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Mode 0 loopback
        loopback = 1'b1;
        xfer(2'd0, 8'hA5, 0, 0);
        check("m0_cs_low", {31'd0, cs_at1}, 32'd0);
        check("m0_done_cyc", done_cyc, 32'd37);
        check("m0_done_cnt", done_cnt, 32'd1);
        check("m0_busy", busy_bad, 32'd0);
        check("m0_rises", n_rise, 32'd8);
        check("m0_mosi_on_rise", chg_on, 32'd0);
        check("m0_rx", {24'd0, rx0}, 32'h0000_00A5);
        check("m0_mosi_hold", {31'd0, mosi0}, 32'd1);

        // Mode 3 against the slave
        loopback = 1'b0;
        s_cpha   = 1'b1;
        s_word   = 8'h3C;
        xfer(2'd3, 8'hFF, 0, 0);
        check("m3_done_cyc", done_cyc, 32'd37);
        check("m3_mosi_on_rise", chg_on, 32'd0);
        check("m3_rx", {24'd0, rx0}, 32'h0000_003C);
        check("m3_slave_rx", {24'd0, s_rx}, 32'h0000_00FF);
        check("m3_sclk_after", {31'd0, sclk0}, 32'd1);

        // Mode 1 against the slave
        s_word = 8'h96;
        xfer(2'd1, 8'h81, 0, 0);
        check("m1_done_cyc", done_cyc, 32'd37);
        check("m1_rises", n_rise, 32'd8);
        check("m1_mosi_off_rise", chg_off, 32'd0);
        check("m1_slave_rx", {24'd0, s_rx}, 32'h0000_0081);
        check("m1_rx", {24'd0, rx0}, 32'h0000_0096);

        // start and mode change mid-transfer are ignored
        loopback = 1'b1;
        xfer(2'd0, 8'hC3, 10, 0);
        check("ign_done_cnt", done_cnt, 32'd1);
        check("ign_done_cyc", done_cyc, 32'd37);
        check("ign_rx", {24'd0, rx0}, 32'h0000_00C3);

        // start coincident with done is ignored (mode 2 loopback)
        xfer(2'd2, 8'h66, 37, 0);
        check("dn_done_cyc", done_cyc, 32'd37);
        check("dn_no_restart", cs_after, 32'd0);
        check("dn_rx", {24'd0, rx0}, 32'h0000_0066);

        // reset mid-transfer aborts without done
        xfer(2'd0, 8'hC3, 0, 20);
        check("ab_done_cnt", done_cnt, 32'd0);
        check("ab_rx", {24'd0, rx0}, 32'd0);
        xfer(2'd0, 8'h5A, 0, 0);
        check("ab_next_done", done_cyc, 32'd37);
        check("ab_next_rx", {24'd0, rx0}, 32'h0000_005A);

        // 32-bit, divide-by-1 loopback
        @(negedge clk);
        tx1    = 32'hDEAD_BEEF;
        start1 = 1'b1;
        d1     = 0;
        for (int j = 1; j <= 80; j++) begin
            @(negedge clk);
            if (j == 1) start1 = 1'b0;
            if (done1 && d1 == 0) d1 = j;
        end
        check("w32_done_cyc", d1, 32'd67);
        check("w32_rx", rx1, 32'hDEAD_BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
